// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter that shares one 4:1 one-bit mux between four
//   requesters. One requester owns the mux at a time. Ownership ends when the
//   owner drops its request, or when it reaches the hold timeout.
//
// Parameters
//   MAX_HOLD  maximum consecutive grant cycles per ownership (0 = no timeout)
//   HOLD_W    hold counter width; must be able to hold MAX_HOLD-1
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous reset, active-high, highest priority
//   en     1 = new grants allowed (ignored while an owner keeps the mux)
//   req    per-requester request bits
//   x      per-requester data bits
//   gnt    registered one-hot grant, 0 when idle
//   s      registered mux select (index of the owner; holds value when idle)
//   valid  registered, equals |gnt
//   y      x[s] while valid, else 0
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    input  logic [3:0] x,
    output logic [3:0] gnt,
    output logic [1:0] s,
    output logic       valid,
    output logic       y
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam bit                TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(MAX_HOLD - 1);

    state_t             state, state_n;
    logic [3:0]         gnt_n;
    logic [1:0]         s_n;
    logic               valid_n;
    logic [1:0]         ptr, ptr_n;
    logic [HOLD_W-1:0]  hold_cnt, hold_cnt_n;
    logic               release_now;
    logic [1:0]         owner_next;

    // First requester at or after index p, wrapping mod 4.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            s        <= '0;
            valid    <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            s        <= s_n;
            valid    <= valid_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        gnt_n       = gnt;
        s_n         = s;
        valid_n     = valid;
        ptr_n       = ptr;
        hold_cnt_n  = hold_cnt;
        release_now = 1'b0;
        owner_next  = s;

        case (state)
            IDLE: begin
                hold_cnt_n = '0;
                if (en && (req != '0)) begin
                    owner_next = pick(req, ptr);
                    state_n    = GRANT;
                    gnt_n      = 4'b0001 << owner_next;
                    s_n        = owner_next;
                    valid_n    = 1'b1;
                end else begin
                    gnt_n   = '0;
                    valid_n = 1'b0;
                end
            end

            GRANT: begin
                release_now = !req[s] || (TIMEOUT_EN && (hold_cnt == HOLD_LAST));
                if (!release_now) begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end else begin
                    ptr_n = s + 2'd1;
                    // No explicit mask is needed: a dropped owner has req[s]=0
                    // already, and a timed-out owner is last when searching
                    // from s+1, so the plain req gives the required order.
                    if (en && (req != '0)) begin
                        owner_next = pick(req, s + 2'd1);
                        state_n    = GRANT;
                        gnt_n      = 4'b0001 << owner_next;
                        s_n        = owner_next;
                        valid_n    = 1'b1;
                        hold_cnt_n = '0;
                    end else begin
                        state_n    = IDLE;
                        gnt_n      = '0;
                        valid_n    = 1'b0;
                        hold_cnt_n = '0;
                    end
                end
            end

            default: begin
                state_n    = IDLE;
                gnt_n      = '0;
                valid_n    = 1'b0;
                hold_cnt_n = '0;
            end
        endcase
    end

    assign y = valid & x[s];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] x;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       valid;
    logic       y;

    int checks;
    int errors;

    mux4_rr_arbiter #(
        .MAX_HOLD(8),
        .HOLD_W  (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .req  (req),
        .x    (x),
        .gnt  (gnt),
        .s    (s),
        .valid(valid),
        .y    (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] eg, input logic [1:0] es,
                         input logic ev, input logic ey);
        checks++;
        assert (gnt === eg) else begin
            errors++;
            $error("FAIL %s gnt: observed %b expected %b", tag, gnt, eg);
        end
        checks++;
        assert (s === es) else begin
            errors++;
            $error("FAIL %s s: observed %0d expected %0d", tag, s, es);
        end
        checks++;
        assert (valid === ev) else begin
            errors++;
            $error("FAIL %s valid: observed %b expected %b", tag, valid, ev);
        end
        checks++;
        assert (y === ey) else begin
            errors++;
            $error("FAIL %s y: observed %b expected %b", tag, y, ey);
        end
    endtask

    initial begin
        logic [1:0] order [5];
        checks = 0;
        errors = 0;
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;

        // 1. reset held two cycles with all requests active
        rst = 1'b1; en = 1'b1; req = 4'b1111; x = 4'b1111;
        step(); check("rst_c1", 4'b0000, 2'd0, 1'b0, 1'b0);
        step(); check("rst_c2", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0; req = 4'b0000;
        step(); check("idle_after_rst", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 2. single request for index 2, y follows x[2]
        req = 4'b0100; x = 4'b0100;
        step(); check("grant2", 4'b0100, 2'd2, 1'b1, 1'b1);
        x = 4'b1011; #1;
        check("grant2_y0", 4'b0100, 2'd2, 1'b1, 1'b0);
        x = 4'b1111; #1;
        check("grant2_y1", 4'b0100, 2'd2, 1'b1, 1'b1);
        req = 4'b0000;
        step(); check("drop2_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
        // ptr is now 3: requesters 0 and 3 compete, 3 must win
        req = 4'b1001;
        step(); check("ptr3_pick3", 4'b1000, 2'd3, 1'b1, 1'b1);
        req = 4'b0000;
        step(); check("drop3_idle", 4'b0000, 2'd3, 1'b0, 1'b0);

        // 3. all requesting, ptr=0: 0,1,2,3,0 for 8 cycles each, no bubble
        req = 4'b1111;
        step();
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 8; c++) begin
                check($sformatf("rr_g%0d_c%0d", g, c), 4'b0001 << order[g], order[g], 1'b1, 1'b1);
                step();
            end
        end
        check("rr_next1", 4'b0010, 2'd1, 1'b1, 1'b1);
        req = 4'b0000;
        step(); check("rr_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

        // 4. lone requester 1 regranted back-to-back across timeouts
        req = 4'b0010; x = 4'b0010;
        step();
        for (int c = 0; c < 20; c++) begin
            check($sformatf("lone_c%0d", c), 4'b0010, 2'd1, 1'b1, 1'b1);
            step();
        end
        req = 4'b0000;
        step(); check("lone_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

        // 5. release with en=0 goes idle; raising en grants 3
        x = 4'b1000;
        req = 4'b0010;
        step(); check("own1", 4'b0010, 2'd1, 1'b1, 1'b0);
        en = 1'b0; req = 4'b1000;
        step(); check("en0_release", 4'b0000, 2'd1, 1'b0, 1'b0);
        step(); check("en0_hold_idle", 4'b0000, 2'd1, 1'b0, 1'b0);
        en = 1'b1;
        step(); check("en1_grant3", 4'b1000, 2'd3, 1'b1, 1'b1);

        // release with immediate regrant, no idle bubble
        req = 4'b0100; x = 4'b0101;
        step(); check("regrant2", 4'b0100, 2'd2, 1'b1, 1'b1);
        req = 4'b0001;
        step(); check("regrant0", 4'b0001, 2'd0, 1'b1, 1'b1);

        // 6. reset mid-grant at hold_cnt=5 (ptr=3 before reset)
        for (int c = 0; c < 5; c++) step();
        check("own0_hold5", 4'b0001, 2'd0, 1'b1, 1'b1);
        rst = 1'b1; req = 4'b1010;
        step(); check("midrst", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0; x = 4'b0010;
        // ptr reset to 0 -> requester 1 wins over 3
        step(); check("after_rst_pick1", 4'b0010, 2'd1, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
